// File: rtl/kernel_write_ctrl_if.sv
// Beat input and bank-write/status output bundle for kernel_write_ctrl.
// The master drives beats and start; the slave (the controller) drives writes and status.
interface kernel_write_ctrl_if #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned QUOT_WIDTH      = 10,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_ADDR_WIDTH = 12,
    parameter int unsigned CNT_WIDTH       = 14
) ();
    logic                       start;
    logic [QUOT_WIDTH-1:0]      i_quotient;
    logic [QUOT_WIDTH-1:0]      i_remainder;
    logic [DATA_WIDTH-1:0]      i_data;
    logic                       i_valid;

    logic [NUM_BANKS-1:0]       o_we;
    logic [BANK_ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0]      o_data;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_err;
    logic [CNT_WIDTH-1:0]       o_word_cnt;
    logic [DATA_WIDTH-1:0]      o_checksum;

    modport master (
        output start, i_quotient, i_remainder, i_data, i_valid,
        input  o_we, o_addr, o_data, o_busy, o_done, o_err, o_word_cnt, o_checksum
    );

    modport slave (
        input  start, i_quotient, i_remainder, i_data, i_valid,
        output o_we, o_addr, o_data, o_busy, o_done, o_err, o_word_cnt, o_checksum
    );
endinterface

// File: rtl/kernel_write_ctrl.sv
// Turns {kernel index, word offset, data} beats into banked weight-buffer writes and
// tracks load progress. Optional running checksum: define KERNEL_WRITE_CHECKSUM_EN.
module kernel_write_ctrl #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned QUOT_WIDTH      = 10,
    parameter int unsigned KERNEL_WORDS    = 288,
    parameter int unsigned NUM_KERNELS     = 32,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_ADDR_WIDTH = 12,
    parameter int unsigned CNT_WIDTH       = 14
) (
    input  logic               clk,
    input  logic               rst,
    kernel_write_ctrl_if.slave bus
);
    localparam int unsigned BANK_BITS   = $clog2(NUM_BANKS);
    localparam int unsigned ADDR_FULL_W = QUOT_WIDTH + $clog2(KERNEL_WORDS + 1) + 1;
    localparam int unsigned TOTAL_WORDS = NUM_KERNELS * KERNEL_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_reg, state_next;
    logic [CNT_WIDTH-1:0]       cnt_reg, cnt_next;
    logic                       err_reg, err_next;
    logic [NUM_BANKS-1:0]       we_reg, we_next;
    logic [BANK_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]      data_reg, data_next;

    logic                       in_range;
    logic                       beat_in_load;
    logic                       accepted;
    logic                       bad_beat;
    logic                       cnt_full;
    logic [QUOT_WIDTH-1:0]      bank_sel;
    logic [ADDR_FULL_W-1:0]     addr_full;

    // Beat classification; start always takes priority over a coincident beat.
    assign in_range     = (32'(bus.i_quotient) < NUM_KERNELS) &&
                          (32'(bus.i_remainder) < KERNEL_WORDS);
    assign beat_in_load = bus.i_valid && (state_reg == LOAD) && !bus.start;
    assign accepted     = beat_in_load && in_range;
    assign bad_beat     = beat_in_load && !in_range;
    assign cnt_full     = (cnt_reg == CNT_WIDTH'(TOTAL_WORDS));

    // Low quotient bits pick the bank, the rest pick the kernel slot inside that bank.
    assign bank_sel  = bus.i_quotient & QUOT_WIDTH'(NUM_BANKS - 1);
    assign addr_full = ADDR_FULL_W'(bus.i_quotient >> BANK_BITS) * ADDR_FULL_W'(KERNEL_WORDS)
                     + ADDR_FULL_W'(bus.i_remainder);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_we
            assign we_next[gi] = accepted && (bank_sel == QUOT_WIDTH'(gi));
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: state_next = IDLE;
            LOAD: if (cnt_full) state_next = DONE;
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (bus.start) begin
            state_next = LOAD;
        end
    end

    // Counter, sticky error and write datapath next values
    always_comb begin
        cnt_next  = cnt_reg;
        err_next  = err_reg;
        addr_next = addr_reg;
        data_next = data_reg;
        if (bus.start) begin
            cnt_next = '0;
            err_next = 1'b0;
        end else begin
            if (accepted && !cnt_full) begin
                cnt_next = cnt_reg + 1'b1;
            end
            if (bad_beat) begin
                err_next = 1'b1;
            end
        end
        if (accepted) begin
            addr_next = BANK_ADDR_WIDTH'(addr_full);
            data_next = bus.i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            we_reg    <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

`ifdef KERNEL_WRITE_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_reg, checksum_next;

    always_comb begin
        checksum_next = checksum_reg;
        if (bus.start) begin
            checksum_next = '0;
        end else if (accepted) begin
            checksum_next = checksum_reg + bus.i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_reg <= '0;
        end else begin
            checksum_reg <= checksum_next;
        end
    end

    assign bus.o_checksum = checksum_reg;
`else
    assign bus.o_checksum = '0;
`endif

    assign bus.o_we       = we_reg;
    assign bus.o_addr     = addr_reg;
    assign bus.o_data     = data_reg;
    assign bus.o_busy     = (state_reg == LOAD);
    assign bus.o_done     = (state_reg == DONE);
    assign bus.o_err      = err_reg;
    assign bus.o_word_cnt = cnt_reg;
endmodule
